// File: rtl/branch_target_unit_if.sv
// Branch descriptor / branch result bus between decode, the target unit
// and fetch.
//
// Valid/ready handshake, for both the descriptor (in_*) and result (out_*)
// channels: a transfer happens on a rising clk edge where valid and ready
// are both 1. A producer that raises valid keeps valid high and its data
// stable until that transfer. Ready may depend combinationally on the
// consumer's state, but valid never depends on ready.
interface branch_target_unit_if #(
  parameter int OFFSET_W = 24,
  parameter int ADDR_W   = 32
);
  // Descriptor channel (decode -> unit)
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_pc;
  logic [OFFSET_W-1:0] in_offset;
  logic [ADDR_W-1:0]   in_base;
  logic [1:0]          in_mode;

  // Result channel (unit -> fetch)
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   out_target;
  logic [ADDR_W-1:0]   out_link;
  logic                out_link_en;
  logic                out_wrap;
  logic                out_misalign;

  // Environment side: sends descriptors, consumes results
  modport master (
    output in_valid, in_pc, in_offset, in_base, in_mode, out_ready,
    input  in_ready, out_valid, out_target, out_link, out_link_en,
           out_wrap, out_misalign
  );

  // Target unit side
  modport slave (
    input  in_valid, in_pc, in_offset, in_base, in_mode, out_ready,
    output in_ready, out_valid, out_target, out_link, out_link_en,
           out_wrap, out_misalign
  );
endinterface

// File: rtl/branch_target_unit.sv
// Two-stage pipelined branch-target calculator.
// S1 registers the biased PC, the scaled/sign-extended offset, the base
// register, the mode and the link address. S2 registers the final target,
// link and flags. Both stages stall under back-pressure and are cleared by
// flush. All address arithmetic is modulo 2^ADDR_W.
module branch_target_unit #(
  parameter int OFFSET_W = 24,
  parameter int ADDR_W   = 32,
  parameter int SHIFT    = 2,
  parameter int PC_BIAS  = 8,
  parameter int LINK_OFS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  branch_target_unit_if.slave  bus
);

  localparam logic [ADDR_W-1:0] BIAS     = ADDR_W'(PC_BIAS);
  localparam logic [ADDR_W-1:0] LINK_ADD = ADDR_W'(LINK_OFS);
  // Low SHIFT bits of an address; zero mask when SHIFT is 0.
  localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << SHIFT) - ADDR_W'(1);

  // ---------------------------------------------------------------------
  // Handshake / stage-advance control
  // ---------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic in_ready_int;
  logic in_fire;
  logic s2_load;

  // S2 can take new data when empty or when its result leaves this edge;
  // S1 can take new data when empty or when it moves into S2.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign in_ready_int = s1_adv && !flush;
  assign in_fire      = bus.in_valid && in_ready_int;
  assign s2_load      = s2_adv && s1_valid && !flush;

  assign bus.in_ready = in_ready_int;

  // ---------------------------------------------------------------------
  // S1 input preparation
  // ---------------------------------------------------------------------
  logic signed [OFFSET_W-1:0] off_s;
  logic [ADDR_W-1:0]          in_ext;
  logic [ADDR_W-1:0]          in_pc_b;
  logic [ADDR_W-1:0]          in_link;

  // Sign-extend the offset to address width, then scale words to bytes;
  // bits pushed above ADDR_W are dropped.
  assign off_s   = bus.in_offset;
  assign in_ext  = ADDR_W'(off_s) << SHIFT;
  assign in_pc_b = bus.in_pc + BIAS;
  assign in_link = bus.in_pc + LINK_ADD;

  // ---------------------------------------------------------------------
  // S1 registers
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] s1_pc_b;
  logic [ADDR_W-1:0] s1_ext;
  logic [ADDR_W-1:0] s1_base;
  logic [ADDR_W-1:0] s1_link;
  logic [1:0]        s1_mode;

  // S1 occupancy: flush empties it, otherwise refill whenever it advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
    end
  end

  // S1 data captures a descriptor only on an accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_pc_b <= '0;
      s1_ext  <= '0;
      s1_base <= '0;
      s1_link <= '0;
      s1_mode <= 2'b00;
    end else if (in_fire) begin
      s1_pc_b <= in_pc_b;
      s1_ext  <= in_ext;
      s1_base <= bus.in_base;
      s1_link <= in_link;
      s1_mode <= bus.in_mode;
    end
  end

  // ---------------------------------------------------------------------
  // S2 result computation
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] rel_target;
  logic              rel_wrap;
  logic [ADDR_W-1:0] abs_target;
  logic              abs_misalign;
  logic [ADDR_W-1:0] nxt_target;
  logic              nxt_wrap;
  logic              nxt_misalign;

  // Relative target with boundary-crossing detection, absolute target with
  // alignment forcing, then select by mode bit 1.
  always_comb begin
    rel_target   = s1_pc_b + s1_ext;
    rel_wrap     = 1'b0;
    abs_target   = s1_base & ~LOW_MASK;
    abs_misalign = |(s1_base & LOW_MASK);
    nxt_target   = rel_target;
    nxt_wrap     = 1'b0;
    nxt_misalign = 1'b0;

    // A non-negative displacement must not land below the biased PC, a
    // negative one must not land above it; otherwise the sum wrapped.
    if (s1_ext[ADDR_W-1]) begin
      rel_wrap = (rel_target > s1_pc_b);
    end else begin
      rel_wrap = (rel_target < s1_pc_b);
    end

    if (s1_mode[1]) begin
      nxt_target   = abs_target;
      nxt_misalign = abs_misalign;
    end else begin
      nxt_wrap     = rel_wrap;
    end
  end

  // ---------------------------------------------------------------------
  // S2 registers (these are the unit's output registers)
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] s2_target;
  logic [ADDR_W-1:0] s2_link;
  logic              s2_link_en;
  logic              s2_wrap;
  logic              s2_misalign;

  // S2 occupancy: flush empties it, otherwise follow S1 when advancing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
    end
  end

  // S2 data loads only when a live S1 entry moves in, so the last result
  // stays visible after it is consumed or flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_target   <= '0;
      s2_link     <= '0;
      s2_link_en  <= 1'b0;
      s2_wrap     <= 1'b0;
      s2_misalign <= 1'b0;
    end else if (s2_load) begin
      s2_target   <= nxt_target;
      s2_link     <= s1_link;
      s2_link_en  <= s1_mode[0];
      s2_wrap     <= nxt_wrap;
      s2_misalign <= nxt_misalign;
    end
  end

  assign bus.out_valid    = s2_valid;
  assign bus.out_target   = s2_target;
  assign bus.out_link     = s2_link;
  assign bus.out_link_en  = s2_link_en;
  assign bus.out_wrap     = s2_wrap;
  assign bus.out_misalign = s2_misalign;

endmodule

// File: tb/tb_branch_target_unit.sv
// Bench for branch_target_unit: table of directed descriptors with
// hand-computed results, plus back-pressure, flush and reset sequences.
module tb_branch_target_unit;

  localparam int OFFSET_W = 24;
  localparam int ADDR_W   = 32;
  localparam int RW       = 2 * ADDR_W + 3;

  typedef struct {
    logic [31:0] pc;
    logic [23:0] offset;
    logic [31:0] base;
    logic [1:0]  mode;
    logic [31:0] target;
    logic [31:0] link;
    logic        link_en;
    logic        wrap;
    logic        misalign;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  branch_target_unit_if #(.OFFSET_W(OFFSET_W), .ADDR_W(ADDR_W)) bus ();

  branch_target_unit #(
    .OFFSET_W(OFFSET_W), .ADDR_W(ADDR_W), .SHIFT(2), .PC_BIAS(8), .LINK_OFS(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  vec_t vecs[8];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cur_exp;
  logic [RW-1:0] sb_e;
  logic          sb_en = 1'b0;
  logic          fire;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack(input vec_t v);
    return {v.target, v.link, v.link_en, v.wrap, v.misalign};
  endfunction

  function automatic logic [RW-1:0] actual();
    return {bus.out_target, bus.out_link, bus.out_link_en, bus.out_wrap, bus.out_misalign};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input int i);
    bus.in_pc     = vecs[i].pc;
    bus.in_offset = vecs[i].offset;
    bus.in_base   = vecs[i].base;
    bus.in_mode   = vecs[i].mode;
    cur_exp       = pack(vecs[i]);
  endtask

  // Present vectors first..first+n-1 back to back until n are accepted.
  // Leaves in_valid high; the caller decides what follows.
  task automatic fill(input int first, input int n);
    int got = 0;
    drive_vec(first);
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 20 && got < n; cyc++) begin
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (fire) begin
        got++;
        if (got < n) drive_vec(first + got);
      end
    end
    check("fill_accepts", got, n);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"},    bus.out_valid,    0);
    check({tag, "_out_target"},   bus.out_target,   0);
    check({tag, "_out_link"},     bus.out_link,     0);
    check({tag, "_out_link_en"},  bus.out_link_en,  0);
    check({tag, "_out_wrap"},     bus.out_wrap,     0);
    check({tag, "_out_misalign"}, bus.out_misalign, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Pops on every result transfer, pushes on every descriptor transfer;
  // flush drops whatever is still in flight after this edge's output.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else if (sb_en) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: actual %0h with nothing expected", actual());
        end else begin
          sb_e = exp_q.pop_front();
          n_pop++;
          check("sb_result", actual(), sb_e);
        end
      end
      if (flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    //             pc            offset      base          mode   target        link          en    wrap  mis
    vecs[0] = '{32'h00000100, 24'h000010, 32'h00000000, 2'b00, 32'h00000148, 32'h00000104, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h00000100, 24'hFFFFFE, 32'h00000000, 2'b01, 32'h00000100, 32'h00000104, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFFFFF0, 24'h000010, 32'h00000000, 2'b00, 32'h00000038, 32'hFFFFFFF4, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h00000000, 24'hFFFFFC, 32'h00000000, 2'b00, 32'hFFFFFFF8, 32'h00000004, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h00002000, 24'h000005, 32'h00008003, 2'b11, 32'h00008000, 32'h00002004, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h00000000, 24'h000000, 32'h12345678, 2'b10, 32'h12345678, 32'h00000004, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h00000010, 24'h800000, 32'h00000000, 2'b01, 32'hFE000018, 32'h00000014, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h7FFFFFF8, 24'h7FFFFF, 32'h00000000, 2'b00, 32'h81FFFFFC, 32'h7FFFFFFC, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_offset = '0;
    bus.in_base   = '0;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b0;
    cur_exp       = '0;
    flush         = 1'b0;
    reset         = 1'b0;
    #1 reset = 1'b1;
    #1 check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);

    // ---- table: one descriptor at a time, latency and data ----
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive_vec(i);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("tbl_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;                        // edge N: accepted
      bus.in_valid = 1'b0;
      bus.in_pc    = 32'hDEADBEEF;               // captured copy must be used
      bus.in_base  = 32'hDEADBEEF;
      @(negedge clk);
      check("tbl_lat_n1_valid", bus.out_valid, 0);
      @(posedge clk);                            // edge N+1
      @(negedge clk);
      check("tbl_lat_n2_valid", bus.out_valid,    1);
      check("tbl_target",       bus.out_target,   vecs[i].target);
      check("tbl_link",         bus.out_link,     vecs[i].link);
      check("tbl_link_en",      bus.out_link_en,  vecs[i].link_en);
      check("tbl_wrap",         bus.out_wrap,     vecs[i].wrap);
      check("tbl_misalign",     bus.out_misalign, vecs[i].misalign);
    end
    @(posedge clk); #1;                          // last result consumed
    @(negedge clk);
    check("tbl_drained_valid", bus.out_valid, 0);

    // ---- back-pressure: 5 descriptors, out_ready low for 4 cycles ----
    sb_en = 1'b1;
    @(posedge clk); #1;
    begin
      int idx = 0;
      int accepts = 0;
      bus.out_ready = 1'b0;
      drive_vec(0);
      bus.in_valid = 1'b1;
      for (int cyc = 0; cyc < 30 && idx < 5; cyc++) begin
        @(negedge clk);
        if (cyc == 2) check("bp_accepts_before_stall", accepts, 2);
        if (cyc == 2 || cyc == 3) check("bp_in_ready_low", bus.in_ready, 0);
        if (cyc == 4) check("bp_ready_follows_out_ready", bus.in_ready, 1);
        fire = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        if (cyc == 3) bus.out_ready = 1'b1;
        if (fire) begin
          accepts++;
          idx++;
          if (idx < 5) drive_vec(idx);
          else bus.in_valid = 1'b0;
        end
      end
      check("bp_accepts", accepts, 5);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
      @(posedge clk); #1;
      check("bp_queue_empty", exp_q.size(), 0);
      check("bp_results_popped", n_pop, 5);
      @(negedge clk);
      check("bp_idle_valid", bus.out_valid, 0);
    end

    // ---- flush with both stages full and a descriptor waiting ----
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    fill(5, 2);
    drive_vec(7);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_pre_valid", bus.out_valid, 1);
    check("flush_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_hold_target", bus.out_target, vecs[5].target);
    check("flush_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_no_ghost", bus.out_valid, 0);
      @(posedge clk); #1;
    end

    // ---- asynchronous reset mid-stall ----
    bus.out_ready = 1'b0;
    fill(1, 2);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", bus.out_valid, 1);
    #2 reset = 1'b1;
    #1 check_zero_outputs("rst_async");
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
